// File: rtl/hyperbus_target_if.sv
// HyperBus follower pin bundle as seen inside the DDR pads.
// master = leader controller side, slave = hyperbus_target.
interface hyperbus_target_if #(
  parameter int WIDTH = 8
);
  logic               hbus_rstn;
  logic               hbus_csn;
  logic [2*WIDTH-1:0] dq_i;
  logic [2*WIDTH-1:0] dq_o;
  logic               dq_oe;
  logic [1:0]         rwds_i;
  logic [1:0]         rwds_o;
  logic               rwds_oe;
  logic               busy;

  modport master (
    output hbus_rstn, hbus_csn, dq_i, rwds_i,
    input  dq_o, dq_oe, rwds_o, rwds_oe, busy
  );

  modport slave (
    input  hbus_rstn, hbus_csn, dq_i, rwds_i,
    output dq_o, dq_oe, rwds_o, rwds_oe, busy
  );
endinterface

// File: rtl/hyperbus_target.sv
// HyperRAM emulator: HyperBus follower backed by on-chip RAM.
// HYPERBUS_TARGET_WRAP_BURST_EN enables 16-word wrapped bursts.
module hyperbus_target #(
  parameter int          WIDTH      = 8,
  parameter int          MEM_AW     = 10,
  parameter int          LATENCY    = 5,
  parameter int          DOUBLE_LAT = 1,
  parameter logic [15:0] ID0_VALUE  = 16'h0C81,
  parameter logic [15:0] CR0_RESET  = 16'h8F1F
) (
  input logic              clk90,
  input logic              rst,
  hyperbus_target_if.slave bus
);
  localparam int DW      = 2 * WIDTH;
  localparam int LAT_CYC = (DOUBLE_LAT != 0) ? 2 * LATENCY : LATENCY;
  localparam logic [7:0] LAT_INIT = 8'(LAT_CYC - 1);
  localparam logic [1:0] CA_RWDS  = (DOUBLE_LAT != 0) ? 2'b11 : 2'b00;

  typedef enum logic [2:0] {
    S_IDLE, S_CA, S_LAT, S_READ, S_WRITE, S_REGWR
  } state_t;

  state_t          state_q, state_d;
  logic            csn_prev_q, csn_prev_d;
  logic [31:0]     ca_hi_q, ca_hi_d;
  logic            ca_cnt_q, ca_cnt_d;
  logic            rw_q, rw_d;
  logic            as_q, as_d;
  logic            burst_q, burst_d;
  logic [31:0]     addr_q, addr_d, addr_nx;
  logic [7:0]      lat_q, lat_d;
  logic [DW-1:0]   cr0_q, cr0_d;
  logic            rgw_done_q, rgw_done_d;
  logic [DW-1:0]   dq_o_q, dq_o_d;
  logic            dq_oe_q, dq_oe_d;
  logic [1:0]      rwds_o_q, rwds_o_d;
  logic            rwds_oe_q, rwds_oe_d;
  logic            busy_q, busy_d;
  logic            we;
  logic [DW-1:0]   rd_word;
  logic [DW-1:0]   mem [2**MEM_AW];

`ifndef HYPERBUS_TARGET_WRAP_BURST_EN
  logic unused_burst;
  assign unused_burst = burst_q;
`endif

  // State register.
  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state; csn high or bus reset always returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (!bus.hbus_csn && csn_prev_q) state_d = S_CA;
      S_CA:
        if (bus.hbus_csn) state_d = S_IDLE;
        else if (ca_cnt_q)
          state_d = (ca_hi_q[30] && !ca_hi_q[31]) ? S_REGWR : S_LAT;
      S_LAT:
        if (bus.hbus_csn) state_d = S_IDLE;
        else if (lat_q == 8'd0)
          state_d = rw_q ? S_READ : S_WRITE;
      S_READ, S_WRITE, S_REGWR:
        if (bus.hbus_csn) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!bus.hbus_rstn) state_d = S_IDLE;
  end

  // Outputs follow the state being entered so they are registered.
  always_comb begin
    dq_o_d    = '0;
    dq_oe_d   = 1'b0;
    rwds_o_d  = 2'b00;
    rwds_oe_d = 1'b0;
    busy_d    = (state_d != S_IDLE);
    unique case (state_d)
      S_CA: begin
        rwds_oe_d = 1'b1;
        rwds_o_d  = CA_RWDS;
      end
      S_READ: begin
        dq_oe_d   = 1'b1;
        rwds_oe_d = 1'b1;
        rwds_o_d  = 2'b10;
        dq_o_d    = rd_word;
      end
      default: ;
    endcase
  end

  // Word presented for the current address (RAM or register space).
  always_comb begin
    rd_word = mem[addr_q[MEM_AW-1:0]];
    if (as_q) begin
      rd_word = '0;
      if (addr_q == 32'h0)        rd_word = DW'(ID0_VALUE);
      else if (addr_q == 32'h800) rd_word = cr0_q;
    end
  end

  // Burst address step: held in register space, else linear or wrapped.
  always_comb begin
    addr_nx = {addr_q[31:MEM_AW], addr_q[MEM_AW-1:0] + MEM_AW'(1)};
`ifdef HYPERBUS_TARGET_WRAP_BURST_EN
    if (!burst_q) addr_nx = {addr_q[31:4], addr_q[3:0] + 4'd1};
`endif
    if (as_q) addr_nx = addr_q;
  end

  // CA capture, latency count, address tracking and CR0 update.
  always_comb begin
    csn_prev_d = bus.hbus_rstn ? bus.hbus_csn : 1'b1;
    ca_hi_d    = ca_hi_q;
    ca_cnt_d   = ca_cnt_q;
    rw_d       = rw_q;
    as_d       = as_q;
    burst_d    = burst_q;
    addr_d     = addr_q;
    lat_d      = lat_q;
    cr0_d      = cr0_q;
    rgw_done_d = rgw_done_q;
    we         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ca_hi_d[31:16] = bus.dq_i;
        ca_cnt_d       = 1'b0;
        rgw_done_d     = 1'b0;
      end
      S_CA:
        if (!ca_cnt_q) begin
          ca_hi_d[15:0] = bus.dq_i;
          ca_cnt_d      = 1'b1;
        end else begin
          rw_d    = ca_hi_q[31];
          as_d    = ca_hi_q[30];
          burst_d = ca_hi_q[29];
          addr_d  = {ca_hi_q[28:0], bus.dq_i[2:0]};
          lat_d   = LAT_INIT;
        end
      S_LAT:
        if (lat_q != 8'd0) lat_d = lat_q - 8'd1;
      S_WRITE:
        if (!bus.hbus_csn && bus.hbus_rstn) begin
          we     = 1'b1;
          addr_d = addr_nx;
        end
      S_REGWR:
        if (!bus.hbus_csn && !rgw_done_q) begin
          rgw_done_d = 1'b1;
          if (addr_q == 32'h800) cr0_d = bus.dq_i;
        end
      default: ;
    endcase
    if (state_d == S_READ) addr_d = addr_nx;
    if (!bus.hbus_rstn) cr0_d = DW'(CR0_RESET);
  end

  // Datapath and output registers.
  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      csn_prev_q <= 1'b1;
      ca_hi_q    <= '0;
      ca_cnt_q   <= 1'b0;
      rw_q       <= 1'b0;
      as_q       <= 1'b0;
      burst_q    <= 1'b0;
      addr_q     <= '0;
      lat_q      <= '0;
      cr0_q      <= DW'(CR0_RESET);
      rgw_done_q <= 1'b0;
      dq_o_q     <= '0;
      dq_oe_q    <= 1'b0;
      rwds_o_q   <= 2'b00;
      rwds_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      csn_prev_q <= csn_prev_d;
      ca_hi_q    <= ca_hi_d;
      ca_cnt_q   <= ca_cnt_d;
      rw_q       <= rw_d;
      as_q       <= as_d;
      burst_q    <= burst_d;
      addr_q     <= addr_d;
      lat_q      <= lat_d;
      cr0_q      <= cr0_d;
      rgw_done_q <= rgw_done_d;
      dq_o_q     <= dq_o_d;
      dq_oe_q    <= dq_oe_d;
      rwds_o_q   <= rwds_o_d;
      rwds_oe_q  <= rwds_oe_d;
      busy_q     <= busy_d;
    end
  end

  // RAM write; an RWDS bit high masks its byte.
  always_ff @(posedge clk90) begin
    if (we && !bus.rwds_i[1])
      mem[addr_q[MEM_AW-1:0]][DW-1:WIDTH] <= bus.dq_i[DW-1:WIDTH];
    if (we && !bus.rwds_i[0])
      mem[addr_q[MEM_AW-1:0]][WIDTH-1:0] <= bus.dq_i[WIDTH-1:0];
  end

  assign bus.dq_o    = dq_o_q;
  assign bus.dq_oe   = dq_oe_q;
  assign bus.rwds_o  = rwds_o_q;
  assign bus.rwds_oe = rwds_oe_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_hyperbus_target.sv
// Randomized bench for hyperbus_target against a
// transaction-level memory/register model.
module tb_hyperbus_target;
  localparam int LAT_CYC = 10;
  localparam logic [15:0] ID0 = 16'h0C81;
  localparam logic [15:0] CR0_RST = 16'h8F1F;

  logic clk90 = 1'b0;
  logic rst = 1'b1;
  always #5 clk90 = ~clk90;

  hyperbus_target_if #(.WIDTH(8)) bus ();

  hyperbus_target dut (
    .clk90 (clk90),
    .rst   (rst),
    .bus   (bus)
  );

  logic [15:0] mem_m [1024];
  logic [15:0] cr0_m;
  logic [15:0] wbuf [1024];
  logic [1:0]  mbuf [1024];
  logic [15:0] rbuf [16];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] baddr(input bit as, input bit bst,
                                        input logic [31:0] a,
                                        input int i);
    bit wrap_en;
`ifdef HYPERBUS_TARGET_WRAP_BURST_EN
    wrap_en = 1'b1;
`else
    wrap_en = 1'b0;
`endif
    if (as) return a;
    if (wrap_en && !bst) return ((a >> 4) << 4) | ((a + i) % 16);
    return a + i;
  endfunction

  function automatic logic [15:0] exp_word(input bit as,
                                           input logic [31:0] a);
    if (as) begin
      if (a == 32'h0) return ID0;
      if (a == 32'h800) return cr0_m;
      return 16'h0000;
    end
    return mem_m[a % 1024];
  endfunction

  task automatic cyc(input logic csn, input logic [15:0] dq,
                     input logic [1:0] rw);
    @(negedge clk90);
    bus.hbus_csn = csn;
    bus.dq_i     = dq;
    bus.rwds_i   = rw;
    @(posedge clk90);
    #1;
  endtask

  task automatic send_ca(input bit rw, input bit as, input bit bst,
                         input logic [31:0] a);
    logic [47:0] ca;
    ca = {rw, as, bst, a[31:3], 13'd0, a[2:0]};
    cyc(1'b0, ca[47:32], 2'b00);
    check("ca_rwds", 32'({bus.rwds_oe, bus.rwds_o}), 32'h7);
    cyc(1'b0, ca[31:16], 2'b00);
    cyc(1'b0, ca[15:0], 2'b00);
    check("ca_end_rwds_oe", 32'(bus.rwds_oe), 32'h0);
  endtask

  task automatic rd(input bit as, input bit bst,
                    input logic [31:0] a, input int n);
    send_ca(1'b1, as, bst, a);
    repeat (LAT_CYC - 1) cyc(1'b0, 16'h0, 2'b00);
    check("lat_dq_oe", 32'(bus.dq_oe), 32'h0);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 16'h0, 2'b00);
      rbuf[i] = bus.dq_o;
      check("rd_strobe",
            32'({bus.dq_oe, bus.rwds_oe, bus.rwds_o}), 32'hE);
      check("rd_data", 32'(bus.dq_o),
            32'(exp_word(as, baddr(as, bst, a, i))));
    end
    cyc(1'b1, 16'h0, 2'b00);
    check("rd_end",
          32'({bus.dq_oe, bus.rwds_oe, bus.busy}), 32'h0);
  endtask

  task automatic wr(input bit bst, input logic [31:0] a,
                    input int n, input int stop);
    logic [31:0] wa;
    send_ca(1'b0, 1'b0, bst, a);
    repeat (LAT_CYC) cyc(1'b0, 16'h0, 2'b00);
    for (int i = 0; i < stop; i++) begin
      cyc(1'b0, wbuf[i], mbuf[i]);
      if (i == 0)
        check("wr_oe", 32'({bus.dq_oe, bus.rwds_oe}), 32'h0);
      wa = baddr(1'b0, bst, a, i) % 1024;
      if (!mbuf[i][1]) mem_m[wa][15:8] = wbuf[i][15:8];
      if (!mbuf[i][0]) mem_m[wa][7:0] = wbuf[i][7:0];
    end
    cyc(1'b1, (stop < n) ? wbuf[stop] : 16'hDEAD, 2'b00);
    check("wr_end",
          32'({bus.dq_oe, bus.rwds_oe, bus.busy}), 32'h0);
  endtask

  task automatic rgw(input logic [31:0] a, input logic [15:0] d);
    send_ca(1'b0, 1'b1, 1'b1, a);
    cyc(1'b0, d, 2'b00);
    cyc(1'b0, ~d, 2'b00);
    cyc(1'b1, 16'h0, 2'b00);
    if (a == 32'h800) cr0_m = d;
    check("rgw_end", 32'(bus.busy), 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    int kind, n;
    bit bst;
    bus.hbus_rstn = 1'b1;
    bus.hbus_csn  = 1'b1;
    bus.dq_i      = 16'h0;
    bus.rwds_i    = 2'b00;
    cr0_m = CR0_RST;
    repeat (3) @(posedge clk90);
    #1;
    check("rst_dq_o", 32'(bus.dq_o), 32'h0);
    check("rst_dq_oe", 32'(bus.dq_oe), 32'h0);
    check("rst_rwds_o", 32'(bus.rwds_o), 32'h0);
    check("rst_rwds_oe", 32'(bus.rwds_oe), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    @(negedge clk90);
    rst = 1'b0;
    cyc(1'b1, 16'h0, 2'b00);

    for (int i = 0; i < 1024; i++) begin
      wbuf[i] = 16'($urandom);
      mbuf[i] = 2'b00;
    end
    wr(1'b1, 32'h0, 1024, 1024);

    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 16'h1111 * 16'(i + 1);
      mbuf[i] = 2'b00;
    end
    wr(1'b1, 32'h10, 4, 4);
    rd(1'b0, 1'b1, 32'h10, 4);
    check("lin_w0", 32'(rbuf[0]), 32'h1111);
    check("lin_w3", 32'(rbuf[3]), 32'h4444);

    wbuf[0] = 16'h1234; mbuf[0] = 2'b00;
    wr(1'b1, 32'h20, 1, 1);
    wbuf[0] = 16'hABCD; mbuf[0] = 2'b01;
    wr(1'b1, 32'h20, 1, 1);
    rd(1'b0, 1'b1, 32'h20, 1);
    check("byte_mask", 32'(rbuf[0]), 32'hAB34);

    rd(1'b1, 1'b1, 32'h0, 2);
    check("id0", 32'(rbuf[0]), 32'h0C81);
    rd(1'b1, 1'b1, 32'h800, 1);
    check("cr0_rst", 32'(rbuf[0]), 32'h8F1F);
    rgw(32'h800, 16'h8F2F);
    rd(1'b1, 1'b1, 32'h800, 1);
    check("cr0_wr", 32'(rbuf[0]), 32'h8F2F);
    rgw(32'h5, 16'h5555);
    rd(1'b1, 1'b1, 32'h5, 1);
    rd(1'b1, 1'b1, 32'h800, 1);

    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 16'($urandom);
      mbuf[i] = 2'b00;
    end
    wr(1'b1, 32'h40, 4, 2);
    rd(1'b0, 1'b1, 32'h40, 4);

    wbuf[0] = 16'hC0DE; wbuf[1] = 16'hF00D;
    mbuf[0] = 2'b00;    mbuf[1] = 2'b00;
    wr(1'b1, 32'h3FF, 2, 2);
    rd(1'b0, 1'b1, 32'h0, 1);
    check("wrap_1k", 32'(rbuf[0]), 32'hF00D);
    rd(1'b0, 1'b1, 32'h3FF, 2);

    cyc(1'b0, 16'hA000, 2'b00);
    cyc(1'b1, 16'h0, 2'b00);
    check("ca_drop_busy", 32'(bus.busy), 32'h0);
    cyc(1'b0, 16'h0000, 2'b00);
    cyc(1'b0, 16'h0001, 2'b00);
    cyc(1'b1, 16'h0010, 2'b00);
    check("ca_drop2_busy", 32'(bus.busy), 32'h0);
    rd(1'b0, 1'b1, 32'h10, 1);

    rd(1'b0, 1'b0, 32'h1E, 4);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      a    = $urandom & 32'h0000_0FFF;
      bst  = 1'($urandom_range(0, 1));
      n    = $urandom_range(1, 8);
      if (kind < 4) begin
        for (int i = 0; i < n; i++) begin
          wbuf[i] = 16'($urandom);
          mbuf[i] = 2'($urandom_range(0, 3));
        end
        wr(bst, a, n, n);
      end else if (kind < 8) begin
        rd(1'b0, bst, a, n);
      end else if (kind == 8) begin
        kind = $urandom_range(0, 2);
        if (kind == 0) a = 32'h0;
        else if (kind == 1) a = 32'h800;
        rd(1'b1, bst, a, n);
      end else begin
        if ($urandom_range(0, 1) == 0) a = 32'h800;
        rgw(a, 16'($urandom));
      end
    end

    send_ca(1'b1, 1'b0, 1'b1, 32'h10);
    repeat (LAT_CYC + 1) cyc(1'b0, 16'h0, 2'b00);
    check("pre_rst_oe", 32'(bus.dq_oe), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst",
          32'({bus.dq_oe, bus.rwds_oe, bus.busy}), 32'h0);
    @(negedge clk90);
    bus.hbus_csn = 1'b1;
    rst = 1'b0;
    cr0_m = CR0_RST;
    cyc(1'b1, 16'h0, 2'b00);
    rd(1'b0, 1'b1, 32'h10, 2);

    rgw(32'h800, 16'h1357);
    wbuf[0] = 16'h600D; wbuf[1] = 16'hBAAD;
    send_ca(1'b0, 1'b0, 1'b1, 32'h80);
    repeat (LAT_CYC) cyc(1'b0, 16'h0, 2'b00);
    cyc(1'b0, wbuf[0], 2'b00);
    mem_m[32'h80] = wbuf[0];
    @(negedge clk90);
    bus.hbus_rstn = 1'b0;
    bus.dq_i = wbuf[1];
    @(posedge clk90);
    #1;
    check("hrst_busy",
          32'({bus.dq_oe, bus.rwds_oe, bus.busy}), 32'h0);
    cr0_m = CR0_RST;
    @(negedge clk90);
    bus.hbus_rstn = 1'b1;
    cyc(1'b1, 16'h0, 2'b00);
    rd(1'b1, 1'b1, 32'h800, 1);
    rd(1'b0, 1'b1, 32'h80, 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/hyperbus_target.md
Name: hyperbus_target

Overview:
- Synthesizable HyperBus follower (HyperRAM emulator) backed by on-chip RAM; it answers the HyperBus leader controller for FPGA loopback and bench use without an external HyperRAM part.
- Core logic is single-edge on posedge clk90, the same clock that drives hbus_clk.
- DDR pad cells sit outside the block, which sees double-width words per clk90 cycle.

Parameters:
- WIDTH, 8, bus byte width; all DDR word ports are 2*WIDTH.
- MEM_AW, 10, word-address bits of internal RAM (2^MEM_AW 16-bit words).
- LATENCY, 5, initial latency in clk90 cycles after the last CA word.
- DOUBLE_LAT, 1, 1 = always signal and apply 2*LATENCY.
- ID0_VALUE, 16'h0C81, value returned for a register read at address 0.
- CR0_RESET, 16'h8F1F, reset value of CR0.

Ports:
- clk90  in  1  bus clock; all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- hbus_rstn  in  1  bus reset, active low; sampled on clk90.
- hbus_csn  in  1  chip select, active low; sampled on clk90.
- dq_i  in  2*WIDTH  captured DQ; [15:8] = rising-edge byte, [7:0] = falling-edge byte.
- dq_o  out  2*WIDTH  DQ to drive, same byte order.
- dq_oe  out  1  DQ output enable.
- rwds_i  in  2  captured RWDS; [1] = rising edge, [0] = falling edge; write byte mask.
- rwds_o  out  2  RWDS to drive.
- rwds_oe  out  1  RWDS output enable.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values (rst high, or hbus_rstn sampled low): state IDLE; dq_o=0, dq_oe=0, rwds_o=0, rwds_oe=0, busy=0; CR0=CR0_RESET. RAM contents are not reset.
- All outputs are registered.
- States: IDLE, CA, LATENCY, READ, WRITE, REGWR.
- IDLE -> CA on first cycle hbus_csn=0. ca word0 = dq_i that cycle.
- CA: capture word1, then word2 (3 words total, MSW first).
  - rwds_oe=1 and rwds_o={2{DOUBLE_LAT}} throughout CA.
  - Decode: rw=ca[47] (1 = read); as=ca[46] (1 = register space); burst=ca[45] (1 = linear).
  - Word address = {ca[44:16], ca[2:0]}, truncated to MEM_AW bits.
- After word2:
  - Register write (as=1, rw=0) -> REGWR (zero latency).
  - Otherwise -> LATENCY with count = (DOUBLE_LAT ? 2*LATENCY : LATENCY) - 1.
  - rwds_oe=0 in LATENCY.
- LATENCY: decrement each cycle; at 0 -> READ if rw else WRITE.
  - On the final LATENCY cycle, issue the RAM read of the first address so data is ready.
- READ: each cycle dq_oe=1, rwds_oe=1, rwds_o=2'b10 (strobe edge-aligned with data), dq_o=current word.
  - Address increments by 1 each cycle.
  - Linear wrap-around at 2^MEM_AW goes to 0.
  - Register reads: addr 0 -> ID0_VALUE; addr 12'h800 -> CR0; all others -> 16'h0000. No address increment in register space.
- WRITE: each cycle writes dq_i to RAM at address, then increments address.
  - Byte [15:8] is written only if rwds_i[1]=0; byte [7:0] only if rwds_i[0]=0.
  - dq_oe=0, rwds_oe=0.
- REGWR: first dq_i word goes into CR0 if address = 12'h800; otherwise discarded. Further words are ignored until csn rises.
- CR0 is observable only by register read; it does not alter LATENCY.
- CSn rise (hbus_csn=1 sampled) in any state -> IDLE on that edge.
  - dq_oe and rwds_oe are 0 from the next cycle.
  - A burst in progress terminates; no write occurs in the cycle csn is sampled high.
  - A transaction with csn high before CA completes is dropped with no side effects.
- csn held low in IDLE after a completed transaction is not possible (csn must toggle). Re-entry to CA requires a 1->0 edge: IDLE tracks previous csn.
- hbus_rstn low mid-burst: immediate return to reset values on the next edge; partial write data already committed stays.

Optional Feature:
- Macro: HYPERBUS_TARGET_WRAP_BURST_EN.
- Defined: burst=0 (wrapped) wraps the address within an aligned 16-word group (addr[3:0] increments; upper bits held). burst=1 is linear.
- Undefined: ca[45] is ignored and all bursts are linear.

Test Plan:
- Reset: assert rst mid-READ -> dq_oe=0, rwds_oe=0, busy=0 within the same edge; subsequent CA is accepted normally.
- Linear write then read: write 4 words 16'h1111..16'h4444 at addr 0x10, mask 2'b00; read 4 at 0x10 -> dq_o = 1111, 2222, 3333, 4444 with rwds_o=2'b10 starting exactly 2*LATENCY cycles after CA word2.
- Byte mask: write 16'hABCD over 16'h1234 with rwds_i=2'b01 -> readback 16'hAB34.
- Register space: read addr 0 -> 16'h0C81; write 16'h8F2F to 0x800 with no latency cycles; read 0x800 -> 16'h8F2F.
- Early terminate: csn high after 2 of 4 write words -> only the first 2 words are written; outputs idle next cycle; address wrap at 2^MEM_AW-1 -> the next word is written to 0.
- Wrap (macro defined): wrapped read starting at addr 0x1E for 4 words -> addresses 1E, 1F, 10, 11.
